// File: rtl/pdm_decimator.sv
// pdm_decimator: PDM bit-clock generator, input synchroniser and 3rd-order CIC decimator with valid/ready output
// ports: clk/rst system clock and sync reset; en run enable; pdm_clk bit clock out; pdm_in async PDM data;
//        pcm/pcm_valid/pcm_ready offset-binary sample handshake; overrun pulses when a pending sample is overwritten
module pdm_decimator #(
  parameter int BITDEPTH   = 14,
  parameter int DECIM_LOG2 = 6,
  parameter int CLKDIV     = 12
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  output logic                pdm_clk,
  input  logic                pdm_in,
  output logic [BITDEPTH-1:0] pcm,
  output logic                pcm_valid,
  input  logic                pcm_ready,
  output logic                overrun
);
  localparam int W  = 3*DECIM_LOG2 + 1;
  localparam int DW = $clog2(CLKDIV);
  logic [DW-1:0]         div_q, div_d;
  logic                  pdm_clk_q, s1_q, s2_q;
  logic [W-1:0]          i1_q, i2_q, i3_q, i1_d, i2_d, i3_d;
  logic [W-1:0]          z1_q, z2_q, z3_q, c1, c2, c3, res_q;
  logic [DECIM_LOG2-1:0] dec_q, dec_d;
  logic [1:0]            warm_q, warm_d;
  logic                  res_v_q, res_v_d, wrap, strobe, last;
  logic [BITDEPTH-1:0]   pcm_q, pcm_d;
  logic                  pcm_valid_q, pcm_valid_d, overrun_q, overrun_d;
  always_comb begin
    wrap        = div_q == DW'(CLKDIV-1);
    strobe      = wrap && pdm_clk_q;
    last        = strobe && dec_q == '1;
    div_d       = wrap ? '0 : div_q + DW'(1);
    dec_d       = strobe ? dec_q + DECIM_LOG2'(1) : dec_q;
    i1_d        = strobe ? i1_q + W'(s2_q) : i1_q;
    i2_d        = strobe ? i2_q + i1_d : i2_q;
    i3_d        = strobe ? i3_q + i2_d : i3_q;
    c1          = i3_d - z1_q;
    c2          = c1 - z2_q;
    c3          = c2 - z3_q;
    warm_d      = (last && warm_q != 2'd3) ? warm_q + 2'd1 : warm_q;
    res_v_d     = last && warm_q == 2'd3;
    pcm_d       = !res_v_q ? pcm_q : res_q[W-1] ? '1 : res_q[W-2 -: BITDEPTH];
    pcm_valid_d = res_v_q || (pcm_valid_q && !pcm_ready);
    overrun_d   = res_v_q && pcm_valid_q && !pcm_ready;
  end
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      div_q     <= '0;
      pdm_clk_q <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      i1_q      <= '0;
      i2_q      <= '0;
      i3_q      <= '0;
      z1_q      <= '0;
      z2_q      <= '0;
      z3_q      <= '0;
      res_q     <= '0;
      res_v_q   <= 1'b0;
      dec_q     <= '0;
      warm_q    <= '0;
    end else begin
      div_q     <= div_d;
      pdm_clk_q <= pdm_clk_q ^ wrap;
      s1_q      <= pdm_in;
      s2_q      <= s1_q;
      i1_q      <= i1_d;
      i2_q      <= i2_d;
      i3_q      <= i3_d;
      dec_q     <= dec_d;
      warm_q    <= warm_d;
      res_v_q   <= res_v_d;
      if (last) begin
        z1_q  <= i3_d;
        z2_q  <= c1;
        z3_q  <= c2;
        res_q <= c3;
      end
    end
    if (rst) begin
      pcm_q       <= '0;
      pcm_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pcm_q       <= pcm_d;
      pcm_valid_q <= pcm_valid_d;
      overrun_q   <= overrun_d;
    end
  end
  assign pdm_clk   = pdm_clk_q;
  assign pcm       = pcm_q;
  assign pcm_valid = pcm_valid_q;
  assign overrun   = overrun_q;
endmodule

// File: tb/tb_pdm_decimator.sv
// tb_pdm_decimator: scoreboard bench for pdm_decimator with directed PDM patterns
module tb_pdm_decimator;
  logic clk = 1'b0, rst = 1'b1, en = 1'b0, pcm_ready = 1'b0;
  logic alt = 1'b0, lvl = 1'b0, tog = 1'b0;
  logic pdm_clk, pdm_in, pcm_valid, overrun;
  logic [13:0] pcm;
  logic [13:0] exp_q[$];
  int xfer_t[$];
  int checks = 0, errors = 0, cyc = 0;
  assign pdm_in = alt ? tog : lvl;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  pdm_decimator dut (
    .clk(clk), .rst(rst), .en(en), .pdm_clk(pdm_clk), .pdm_in(pdm_in),
    .pcm(pcm), .pcm_valid(pcm_valid), .pcm_ready(pcm_ready), .overrun(overrun)
  );
  task automatic chk(input string nm, input int got, input int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, want, want);
    end
  endtask
  initial forever begin
    @(posedge pdm_clk);
    #1 tog = ~tog;
  end
  initial forever begin
    @(negedge clk);
    if (pcm_valid && pcm_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_sample got pcm=0x%0h with empty scoreboard", pcm);
      end else begin
        chk("pcm_sample", int'(pcm), int'(exp_q.pop_front()));
        xfer_t.push_back(cyc);
      end
    end
  end
  task automatic drv();
    @(posedge clk);
    #2;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start(input logic a, input logic l, input logic r);
    drv();
    rst = 1'b1; en = 1'b0; alt = a; lvl = l;
    drv();
    rst = 1'b0; en = 1'b1; pcm_ready = r;
  endtask
  task automatic latency(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!pcm_valid && n < 8000);
  endtask
  task automatic drain(input int lim);
    int n = 0;
    while (exp_q.size() != 0 && n < lim) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
    #2 pcm_ready = 1'b0;
  endtask
  initial begin
    int n, h, l, k, ovc, ovp, vdrop;
    logic ov_prev;
    repeat (4) @(posedge clk);
    #1;
    chk("reset_pcm", int'(pcm), 0);
    chk("reset_valid", int'(pcm_valid), 0);
    chk("reset_overrun", int'(overrun), 0);
    chk("reset_pdm_clk", int'(pdm_clk), 0);
    #1;
    rst = 1'b0; lvl = 1'b1; pcm_ready = 1'b1; en = 1'b1;
    repeat (3) exp_q.push_back(14'h3FFF);
    xfer_t.delete();
    latency(n);
    chk("first_valid_latency", n, 6145);
    h = 0; l = 0; k = 0;
    while (pdm_clk && k < 100) begin step(); k++; end
    while (!pdm_clk && k < 100) begin step(); k++; end
    while (pdm_clk && k < 100) begin h++; step(); k++; end
    while (!pdm_clk && k < 100) begin l++; step(); k++; end
    chk("pdm_clk_high", h, 12);
    chk("pdm_clk_low", l, 12);
    drain(5000);
    chk("xfer_count", xfer_t.size(), 3);
    if (xfer_t.size() >= 3) begin
      chk("spacing_1", xfer_t[1] - xfer_t[0], 1536);
      chk("spacing_2", xfer_t[2] - xfer_t[1], 1536);
    end
    start(1'b0, 1'b0, 1'b1);
    repeat (3) exp_q.push_back(14'h0000);
    drain(12000);
    start(1'b1, 1'b0, 1'b1);
    repeat (3) exp_q.push_back(14'h2000);
    drain(12000);
    start(1'b1, 1'b0, 1'b0);
    exp_q.push_back(14'h2000);
    latency(n);
    chk("ovr_first_latency", n, 6145);
    ovc = 0; ovp = 0; vdrop = 0; ov_prev = 1'b0;
    repeat (1700) begin
      step();
      if (overrun) ovc++;
      if (overrun && !ov_prev) ovp++;
      if (!pcm_valid) vdrop++;
      ov_prev = overrun;
    end
    chk("overrun_pulses", ovp, 1);
    chk("overrun_cycles", ovc, 1);
    chk("valid_dropped_cycles", vdrop, 0);
    #1 pcm_ready = 1'b1;
    step();
    chk("valid_after_take", int'(pcm_valid), 0);
    #1 pcm_ready = 1'b0;
    chk("ovr_scoreboard_empty", exp_q.size(), 0);
    start(1'b0, 1'b1, 1'b1);
    repeat (2) exp_q.push_back(14'h3FFF);
    drain(12000);
    repeat (700) step();
    #1 rst = 1'b1;
    step();
    chk("midrst_pcm", int'(pcm), 0);
    chk("midrst_valid", int'(pcm_valid), 0);
    chk("midrst_pdm_clk", int'(pdm_clk), 0);
    chk("midrst_overrun", int'(overrun), 0);
    #1;
    rst = 1'b0; pcm_ready = 1'b1;
    exp_q.push_back(14'h3FFF);
    latency(n);
    chk("midrst_latency", n, 6145);
    drain(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
